// File: rtl/sparc_mem_pkg.sv
// Shared types and constants for the SPARC datapath memory access sequencer.
package sparc_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StWait,
    StDone,
    StAbort
  } seq_state_e;

  typedef enum logic {
    OwnerFetch = 1'b0,
    OwnerData  = 1'b1
  } owner_e;

  localparam logic [5:0] OP_LDW = 6'b000000;
  localparam logic [5:0] OP_STW = 6'b000100;

  localparam logic [2:0] TT_IACC = 3'b001;
  localparam logic [2:0] TT_DACC = 3'b010;

  // op3 bit 2 distinguishes stores from loads.
  function automatic logic is_store(input logic [5:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mfc_watchdog.sv
// Cycle counter for WAIT; expired flags the last cycle before a transaction is aborted.
module mfc_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic Clk,
  input  logic RESET,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CntLast);

endmodule

// File: rtl/mem_access_sequencer.sv
// Arbitrates the shared MAR/MDR/RAM port between instruction fetch and load/store,
// sequencing each access and aborting with an access trap when MFC never arrives.
module mem_access_sequencer
  import sparc_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       RESET,
  input  logic       fetch_req,
  input  logic       data_req,
  input  logic [5:0] data_op,
  input  logic       MFC,
  output logic       MAR_Enable,
  output logic       MDR_Enable,
  output logic       MDR_Mux_select,
  output logic       RAM_enable,
  output logic [5:0] RAM_OpCode,
  output logic       busy,
  output logic       fetch_done,
  output logic       data_done,
  output logic       trap_req,
  output logic [2:0] tt
);

  seq_state_e state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [5:0] op_q, op_d;
  logic       wd_clr, wd_inc, wd_expired;
  logic       store;

  assign store = (owner_q == OwnerData) && is_store(op_q);

  mfc_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .Clk    (Clk),
    .RESET  (RESET),
    .clr    (wd_clr),
    .inc    (wd_inc),
    .expired(wd_expired)
  );

  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
      owner_q <= OwnerFetch;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    op_d           = op_q;
    wd_clr         = 1'b1;
    wd_inc         = 1'b0;
    MAR_Enable     = 1'b0;
    MDR_Enable     = 1'b0;
    MDR_Mux_select = 1'b0;
    RAM_enable     = 1'b0;
    RAM_OpCode     = '0;
    busy           = 1'b0;
    fetch_done     = 1'b0;
    data_done      = 1'b0;
    trap_req       = 1'b0;
    tt             = '0;

    unique case (state_q)
      StIdle: begin
        // Data side has fixed priority; a waiting fetch has no starvation limit.
        if (data_req) begin
          owner_d = OwnerData;
          op_d    = data_op;
          state_d = StAddr;
        end else if (fetch_req) begin
          owner_d = OwnerFetch;
          op_d    = OP_LDW;
          state_d = StAddr;
        end
      end
      StAddr: begin
        busy       = 1'b1;
        MAR_Enable = 1'b1;
        MDR_Enable = store;
        state_d    = StWait;
      end
      StWait: begin
        busy       = 1'b1;
        RAM_enable = 1'b1;
        RAM_OpCode = op_q;
        wd_clr     = 1'b0;
        // Completion beats timeout when MFC lands on the last watchdog cycle.
        if (MFC) begin
          MDR_Enable     = !store;
          MDR_Mux_select = !store;
          state_d        = StDone;
        end else if (wd_expired) begin
          state_d = StAbort;
        end else begin
          wd_inc = 1'b1;
        end
      end
      StDone: begin
        busy       = 1'b1;
        fetch_done = (owner_q == OwnerFetch);
        data_done  = (owner_q == OwnerData);
        state_d    = StIdle;
      end
      StAbort: begin
        busy       = 1'b1;
        trap_req   = 1'b1;
        tt         = (owner_q == OwnerData) ? TT_DACC : TT_IACC;
        fetch_done = (owner_q == OwnerFetch);
        data_done  = (owner_q == OwnerData);
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed scenarios plus randomized traffic against a
// transaction-level reference model compared on every falling clock edge.
module tb_mem_access_sequencer;

  localparam int unsigned TIMEOUT = 6;

  logic       Clk = 1'b0;
  logic       RESET, fetch_req, data_req, MFC;
  logic [5:0] data_op;
  logic       MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable;
  logic [5:0] RAM_OpCode;
  logic       busy, fetch_done, data_done, trap_req;
  logic [2:0] tt;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  mem_access_sequencer #(
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk           (Clk),
    .RESET         (RESET),
    .fetch_req     (fetch_req),
    .data_req      (data_req),
    .data_op       (data_op),
    .MFC           (MFC),
    .MAR_Enable    (MAR_Enable),
    .MDR_Enable    (MDR_Enable),
    .MDR_Mux_select(MDR_Mux_select),
    .RAM_enable    (RAM_enable),
    .RAM_OpCode    (RAM_OpCode),
    .busy          (busy),
    .fetch_done    (fetch_done),
    .data_done     (data_done),
    .trap_req      (trap_req),
    .tt            (tt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Reference model: a transaction is "age" cycles old; age 0 is the address cycle,
  // ages 1..TIMEOUT are RAM cycles, then one closing cycle (done or abort).
  bit         m_act  = 1'b0;
  bit         m_data = 1'b0;
  int         m_age  = 0;
  int         m_end  = 0;
  logic [5:0] m_op   = '0;

  always @(negedge Clk) begin : model_cmp
    logic       e_mar, e_mdr, e_mux, e_ren, e_bsy, e_fd, e_dd, e_tr, st;
    logic [5:0] e_op;
    logic [2:0] e_tt;
    logic [17:0] exp_v, got_v;
    e_mar = 0; e_mdr = 0; e_mux = 0; e_ren = 0; e_bsy = 0;
    e_fd = 0; e_dd = 0; e_tr = 0; e_op = '0; e_tt = '0;
    st = m_data && m_op[2];
    if (RESET) begin
      m_act = 0;
    end else if (!m_act) begin
      if (data_req) begin
        m_act = 1; m_data = 1; m_op = data_op; m_age = 0; m_end = 0;
      end else if (fetch_req) begin
        m_act = 1; m_data = 0; m_op = 6'b000000; m_age = 0; m_end = 0;
      end
    end else if (m_end != 0) begin
      e_bsy = 1; e_fd = !m_data; e_dd = m_data;
      if (m_end == 2) begin
        e_tr = 1;
        e_tt = m_data ? 3'b010 : 3'b001;
      end
      m_act = 0;
    end else if (m_age == 0) begin
      e_bsy = 1; e_mar = 1; e_mdr = st;
      m_age = 1;
    end else begin
      e_bsy = 1; e_ren = 1; e_op = m_op;
      if (MFC) begin
        e_mdr = !st; e_mux = !st; m_end = 1;
      end else if (m_age == int'(TIMEOUT)) begin
        m_end = 2;
      end else begin
        m_age++;
      end
    end
    exp_v = {e_mar, e_mdr, e_mux, e_ren, e_op, e_bsy, e_fd, e_dd, e_tr, e_tt};
    got_v = {MAR_Enable, MDR_Enable, MDR_Mux_select, RAM_enable, RAM_OpCode,
             busy, fetch_done, data_done, trap_req, tt};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL model_cmp at %0t: got {mar,mdr,mux,ren,op,busy,fd,dd,trap,tt}=%b expected %b",
               $time, got_v, exp_v);
    end
  end

  task automatic abort_run(input bit use_data, input logic [5:0] op);
    if (use_data) begin data_req = 1; data_op = op; end
    else fetch_req = 1;
    MFC = 0;
    tick();
    chk("abort_addr_mar", MAR_Enable, 1);
    for (int k = 0; k < int'(TIMEOUT); k++) begin
      tick();
      chk("abort_wait_ram_en", RAM_enable, 1);
      chk("abort_wait_no_trap", trap_req, 0);
    end
    tick();
    chk("abort_trap", trap_req, 1);
    chk("abort_tt", tt, use_data ? 3'b010 : 3'b001);
    chk("abort_done", use_data ? data_done : fetch_done, 1);
    chk("abort_ram_off", RAM_enable, 0);
    fetch_req = 0; data_req = 0;
    tick();
    chk("abort_trap_clear", trap_req, 0);
    chk("abort_tt_clear", tt, 0);
    chk("abort_idle", busy, 0);
  endtask

  initial begin
    int wc, dd_at, fd_at;
    RESET = 1; fetch_req = 0; data_req = 0; MFC = 0; data_op = '0;
    repeat (2) tick();
    chk("reset_busy", busy, 0);
    chk("reset_ram_en", RAM_enable, 0);
    chk("reset_opcode", RAM_OpCode, 0);
    chk("reset_tt", tt, 0);
    RESET = 0;
    tick();

    // Minimum-latency fetch with MFC tied high.
    fetch_req = 1; MFC = 1;
    tick();
    chk("t1_mar", MAR_Enable, 1);
    chk("t1_addr_no_ram", RAM_enable, 0);
    tick();
    chk("t1_ram_en", RAM_enable, 1);
    chk("t1_opcode", RAM_OpCode, 6'b000000);
    chk("t1_mdr", MDR_Enable, 1);
    chk("t1_mux", MDR_Mux_select, 1);
    tick();
    chk("t1_fetch_done", fetch_done, 1);
    fetch_req = 0; MFC = 0;
    tick();
    chk("t1_idle", busy, 0);

    // Store, MFC delayed four cycles; data_op wiggles after grant.
    data_req = 1; data_op = 6'b000100;
    tick();
    chk("t2_mar", MAR_Enable, 1);
    chk("t2_mdr", MDR_Enable, 1);
    chk("t2_mux", MDR_Mux_select, 0);
    data_op = 6'b111011;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t2_ram_en", RAM_enable, 1);
      chk("t2_opcode", RAM_OpCode, 6'b000100);
      chk("t2_no_mdr", MDR_Enable, 0);
      if (k == 4) begin
        MFC = 1;
        #1 chk("t2_mfc_no_mdr", MDR_Enable, 0);
      end
    end
    tick();
    chk("t2_data_done", data_done, 1);
    chk("t2_ram_off", RAM_enable, 0);
    data_req = 0; MFC = 0;
    tick();
    chk("t2_idle", busy, 0);

    // Simultaneous requests: data first, fetch re-granted right after.
    fetch_req = 1; data_req = 1; data_op = 6'b000000;
    wc = 0; dd_at = -1; fd_at = -1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (data_done) begin dd_at = c; data_req = 0; end
      if (fetch_done) begin fd_at = c; fetch_req = 0; end
      wc = RAM_enable ? wc + 1 : 0;
      MFC = (wc >= 2);
      if (fd_at >= 0) break;
    end
    chk("t3_data_done_cycle", dd_at, 3);
    chk("t3_fetch_gap", fd_at - dd_at, 5);
    fetch_req = 0; data_req = 0; MFC = 0;
    tick();

    abort_run(1'b0, 6'b000000);
    abort_run(1'b1, 6'b001001);

    // Reset in WAIT kills the transaction silently.
    fetch_req = 1;
    tick();
    tick();
    chk("t5_in_wait", RAM_enable, 1);
    #2 RESET = 1;
    #1 chk("t5_async_ram_off", RAM_enable, 0);
    chk("t5_async_idle", busy, 0);
    fetch_req = 0;
    tick();
    RESET = 0;
    tick();
    chk("t5_no_done", fetch_done, 0);
    chk("t5_no_trap", trap_req, 0);
    fetch_req = 1; MFC = 1;
    repeat (3) tick();
    chk("t5_new_fetch_done", fetch_done, 1);
    fetch_req = 0; MFC = 0;
    tick();

    // MFC outside WAIT is ignored.
    MFC = 1;
    tick();
    chk("t6_idle_mfc", busy, 0);
    chk("t6_idle_no_mdr", MDR_Enable, 0);
    fetch_req = 1;
    tick();
    chk("t6_addr_mar", MAR_Enable, 1);
    chk("t6_addr_no_mdr", MDR_Enable, 0);
    MFC = 0;
    tick();
    chk("t6_wait1", RAM_enable, 1);
    tick();
    chk("t6_wait2", RAM_enable, 1);
    MFC = 1;
    #1 chk("t6_mdr_on_mfc", MDR_Enable, 1);
    tick();
    chk("t6_fetch_done", fetch_done, 1);
    fetch_req = 0; MFC = 0;
    tick();

    // Randomized traffic, including occasional async resets.
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (fetch_done) fetch_req = 0;
      else if (!fetch_req && $urandom_range(0, 3) == 0) fetch_req = 1;
      if (data_done) data_req = 0;
      else if (!data_req && $urandom_range(0, 3) == 0) data_req = 1;
      data_op = 6'($urandom_range(0, 63));
      MFC     = ($urandom_range(0, 3) == 0);
      RESET   = ($urandom_range(0, 299) == 0);
    end
    RESET = 0; fetch_req = 0; data_req = 0; MFC = 0;
    repeat (TIMEOUT + 4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
